// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one register-bus core chain between two requesters
// (M0 = UART bridge receive path, M1 = local master). Each requester has a
// one-deep pending slot; requests are issued one at a time, round-robin,
// and the chain's echoed response is routed back only to the issuer.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   - a WAIT lasting TIMEOUT_CYCLES cycles is aborted with a forced
//               zero-data response to the owner and a timeout_o pulse.
//   undefined - WAIT lasts until a response arrives; timeout_o is tied 0.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] m0_addr_i,
  input  logic [15:0] m0_data_i,
  input  logic        m0_rw_i,
  input  logic        m0_valid_i,
  input  logic [15:0] m1_addr_i,
  input  logic [15:0] m1_data_i,
  input  logic        m1_rw_i,
  input  logic        m1_valid_i,
  output logic [15:0] m0_data_o,
  output logic        m0_rw_o,
  output logic        m0_valid_o,
  output logic        m0_drop_o,
  output logic [15:0] m1_data_o,
  output logic        m1_rw_o,
  output logic        m1_valid_o,
  output logic        m1_drop_o,
  output logic [15:0] bus_addr_o,
  output logic [15:0] bus_data_o,
  output logic        bus_rw_o,
  output logic        bus_valid_o,
  input  logic [15:0] bus_data_i,
  input  logic        bus_rw_i,
  input  logic        bus_valid_i,
  output logic        busy_o,
  output logic        timeout_o
);

  // The timeout counter must be able to hold TIMEOUT_CYCLES.
  if ((1 << TO_W) <= TIMEOUT_CYCLES) begin : g_bad_to_w
    $error("bus_arbiter: TO_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic        owner;   // 0 = M0, 1 = M1
  logic        prio;    // requester favoured when both are pending

  logic [15:0] s0_addr, s0_data, s1_addr, s1_data;
  logic        s0_rw, s1_rw, s0_full, s1_full;

  logic        req0, req1, sel1, issue, iss0, iss1;
  logic        cap0, cap1, drop0, drop1;
  logic [15:0] e0_addr, e0_data, e1_addr, e1_data;
  logic        e0_rw, e1_rw;
  logic        to_hit, to_fire, rsp, rsp_rw;
  logic [15:0] rsp_data;

  // A request can be issued straight from the input when its slot is empty,
  // which gives the one-cycle issue latency from an idle arbiter.
  assign req0    = s0_full | m0_valid_i;
  assign req1    = s1_full | m1_valid_i;
  assign e0_addr = s0_full ? s0_addr : m0_addr_i;
  assign e0_data = s0_full ? s0_data : m0_data_i;
  assign e0_rw   = s0_full ? s0_rw   : m0_rw_i;
  assign e1_addr = s1_full ? s1_addr : m1_addr_i;
  assign e1_data = s1_full ? s1_data : m1_data_i;
  assign e1_rw   = s1_full ? s1_rw   : m1_rw_i;

  assign sel1  = req1 & (~req0 | prio);
  assign issue = (state == IDLE) & (req0 | req1);
  assign iss0  = issue & ~sel1;
  assign iss1  = issue & sel1;

  // A full slot being issued this edge frees up for a new arrival; an empty
  // slot issued from the bypass path stays empty.
  assign cap0  = m0_valid_i & (s0_full ? iss0 : ~iss0);
  assign cap1  = m1_valid_i & (s1_full ? iss1 : ~iss1);
  assign drop0 = m0_valid_i & s0_full & ~iss0;
  assign drop1 = m1_valid_i & s1_full & ~iss1;

  // A real response wins over a timeout landing in the same cycle.
  assign to_fire  = to_hit & ~bus_valid_i;
  assign rsp      = (state == WAIT) & (bus_valid_i | to_fire);
  assign rsp_data = to_fire ? 16'h0000 : bus_data_i;
  assign rsp_rw   = to_fire ? bus_rw_o : bus_rw_i;

  assign busy_o = (state == WAIT);

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  assign to_hit = (state == WAIT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Count WAIT cycles since issue and pulse timeout_o on an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= rsp & to_fire;
      if (issue) begin
        to_cnt <= '0;
      end else if (state == WAIT) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Pending slots: capture on arrival, clear when issued, hold when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_addr <= '0;
      s0_data <= '0;
      s0_rw   <= 1'b0;
      s0_full <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
      s1_rw   <= 1'b0;
      s1_full <= 1'b0;
    end else begin
      if (cap0) begin
        s0_addr <= m0_addr_i;
        s0_data <= m0_data_i;
        s0_rw   <= m0_rw_i;
      end
      if (cap1) begin
        s1_addr <= m1_addr_i;
        s1_data <= m1_data_i;
        s1_rw   <= m1_rw_i;
      end
      s0_full <= cap0 | (s0_full & ~iss0);
      s1_full <= cap1 | (s1_full & ~iss1);
    end
  end

  // Issue/response FSM with registered bus and requester outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      prio        <= 1'b0;
      bus_addr_o  <= '0;
      bus_data_o  <= '0;
      bus_rw_o    <= 1'b0;
      bus_valid_o <= 1'b0;
      m0_data_o   <= '0;
      m0_rw_o     <= 1'b0;
      m0_valid_o  <= 1'b0;
      m0_drop_o   <= 1'b0;
      m1_data_o   <= '0;
      m1_rw_o     <= 1'b0;
      m1_valid_o  <= 1'b0;
      m1_drop_o   <= 1'b0;
    end else begin
      bus_valid_o <= 1'b0;
      m0_valid_o  <= 1'b0;
      m1_valid_o  <= 1'b0;
      m0_drop_o   <= drop0;
      m1_drop_o   <= drop1;
      case (state)
        IDLE: begin
          if (issue) begin
            bus_addr_o  <= sel1 ? e1_addr : e0_addr;
            bus_data_o  <= sel1 ? e1_data : e0_data;
            bus_rw_o    <= sel1 ? e1_rw   : e0_rw;
            bus_valid_o <= 1'b1;
            owner       <= sel1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (rsp) begin
            if (owner) begin
              m1_valid_o <= 1'b1;
              m1_data_o  <= rsp_data;
              m1_rw_o    <= rsp_rw;
            end else begin
              m0_valid_o <= 1'b1;
              m0_data_o  <= rsp_data;
              m0_rw_o    <= rsp_rw;
            end
            prio  <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed vectors against a configurable-latency
// echo chain. Reads return 16'hBEED + addr; writes echo the write data.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] m0_addr_i = '0, m0_data_i = '0, m1_addr_i = '0, m1_data_i = '0;
  logic        m0_rw_i = 1'b0, m0_valid_i = 1'b0, m1_rw_i = 1'b0, m1_valid_i = 1'b0;
  logic [15:0] m0_data_o, m1_data_o, bus_addr_o, bus_data_o, bus_data_i;
  logic        m0_rw_o, m0_valid_o, m0_drop_o, m1_rw_o, m1_valid_o, m1_drop_o;
  logic        bus_rw_o, bus_valid_o, bus_rw_i, bus_valid_i, busy_o, timeout_o;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(16), .TO_W(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_rw_i(m0_rw_i), .m0_valid_i(m0_valid_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_rw_i(m1_rw_i), .m1_valid_i(m1_valid_i),
    .m0_data_o(m0_data_o), .m0_rw_o(m0_rw_o), .m0_valid_o(m0_valid_o), .m0_drop_o(m0_drop_o),
    .m1_data_o(m1_data_o), .m1_rw_o(m1_rw_o), .m1_valid_o(m1_valid_o), .m1_drop_o(m1_drop_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_rw_o(bus_rw_o), .bus_valid_o(bus_valid_o),
    .bus_data_i(bus_data_i), .bus_rw_i(bus_rw_i), .bus_valid_i(bus_valid_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Echo chain model; lat = 0 means the chain never answers.
  int          lat = 1;
  int          dly;
  logic        pend, mdl_vld, mdl_rw, p_rw;
  logic [15:0] mdl_data, p_data;
  logic        inj_vld = 1'b0, inj_rw = 1'b0;
  logic [15:0] inj_data = '0;

  assign bus_valid_i = mdl_vld | inj_vld;
  assign bus_data_i  = inj_vld ? inj_data : mdl_data;
  assign bus_rw_i    = inj_vld ? inj_rw : mdl_rw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_vld <= 1'b0; mdl_data <= '0; mdl_rw <= 1'b0;
      pend <= 1'b0; dly <= 0; p_data <= '0; p_rw <= 1'b0;
    end else begin
      mdl_vld <= 1'b0;
      if (pend) begin
        if (dly <= 1) begin
          mdl_vld <= 1'b1; mdl_data <= p_data; mdl_rw <= p_rw; pend <= 1'b0;
        end else begin
          dly <= dly - 1;
        end
      end
      if (bus_valid_o && lat > 0) begin
        if (lat == 1) begin
          mdl_vld  <= 1'b1;
          mdl_data <= bus_rw_o ? bus_data_o : 16'hBEED + bus_addr_o;
          mdl_rw   <= bus_rw_o;
        end else begin
          pend   <= 1'b1;
          dly    <= lat - 1;
          p_data <= bus_rw_o ? bus_data_o : 16'hBEED + bus_addr_o;
          p_rw   <= bus_rw_o;
        end
      end
    end
  end

  // Event counters and grant log, updated just after each rising edge.
  int          m0_vcnt = 0, m1_vcnt = 0, m0_dcnt = 0, m1_dcnt = 0, to_pulses = 0, gn = 0;
  logic [15:0] glog [64];

  always @(posedge clk) begin
    #1;
    if (m0_valid_o) m0_vcnt++;
    if (m1_valid_o) m1_vcnt++;
    if (m0_drop_o)  m0_dcnt++;
    if (m1_drop_o)  m1_dcnt++;
    if (timeout_o)  to_pulses++;
    if (bus_valid_o && gn < 64) begin
      glog[gn] = bus_addr_o;
      gn++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic [15:0] a, input logic [15:0] d, input logic rw);
    if (m == 0) begin
      m0_addr_i = a; m0_data_i = d; m0_rw_i = rw; m0_valid_i = 1'b1;
    end else begin
      m1_addr_i = a; m1_data_i = d; m1_rw_i = rw; m1_valid_i = 1'b1;
    end
  endtask

  task automatic clr();
    m0_valid_i = 1'b0;
    m1_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    inj_vld = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_resp(input int m, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((m == 0) ? m0_valid_o : m1_valid_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_bus(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (bus_valid_o) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, b0, b1, bg, bd;

    // Reset state
    rst_n = 1'b0;
    tick();
    chk("rst_bus_valid", bus_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_m0_valid", m0_valid_o, 0);
    chk("rst_m1_valid", m1_valid_o, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_drops", {m0_drop_o, m1_drop_o}, 0);
    chk("rst_timeout", timeout_o, 0);

    // Single read
    do_reset();
    lat = 1;
    b1 = m1_vcnt;
    drive(0, 16'h0002, 16'h0000, 1'b0);
    tick();
    clr();
    chk("rd_bus_valid", bus_valid_o, 1);
    chk("rd_bus_addr", bus_addr_o, 16'h0002);
    chk("rd_bus_rw", bus_rw_o, 0);
    chk("rd_busy", busy_o, 1);
    wait_resp(0, 10, n);
    chk("rd_latency", n, 2);
    chk("rd_m0_data", m0_data_o, 16'hBEEF);
    chk("rd_m0_rw", m0_rw_o, 0);
    chk("rd_busy_done", busy_o, 0);
    tick();
    chk("rd_m0_valid_pulse", m0_valid_o, 0);
    chk("rd_m1_never", m1_vcnt - b1, 0);

    // Simultaneous requests
    do_reset();
    b0 = m0_vcnt; b1 = m1_vcnt; bd = m0_dcnt + m1_dcnt;
    drive(0, 16'h0000, 16'h0001, 1'b1);
    drive(1, 16'h0001, 16'h0000, 1'b0);
    tick();
    clr();
    chk("sim_bus_addr0", bus_addr_o, 16'h0000);
    chk("sim_bus_data0", bus_data_o, 16'h0001);
    chk("sim_bus_rw0", bus_rw_o, 1);
    wait_resp(0, 10, n);
    chk("sim_m0_latency", n, 2);
    chk("sim_m0_data", m0_data_o, 16'h0001);
    chk("sim_m0_rw", m0_rw_o, 1);
    chk("sim_m1_not_yet", m1_valid_o, 0);
    wait_bus(10, n);
    chk("sim_m1_issue_gap", n, 1);
    chk("sim_bus_addr1", bus_addr_o, 16'h0001);
    chk("sim_bus_rw1", bus_rw_o, 0);
    wait_resp(1, 10, n);
    chk("sim_m1_latency", n, 2);
    chk("sim_m1_data", m1_data_o, 16'hBEEE);
    chk("sim_m1_rw", m1_rw_o, 0);
    chk("sim_m0_count", m0_vcnt - b0, 1);
    chk("sim_m1_count", m1_vcnt - b1, 1);
    chk("sim_no_drops", m0_dcnt + m1_dcnt - bd, 0);

    // Slot overflow with a 10-cycle chain
    do_reset();
    lat = 10;
    bg = gn; bd = m1_dcnt;
    drive(1, 16'h000A, 16'h0000, 1'b0);
    tick();
    chk("ovf_issue_a", bus_addr_o, 16'h000A);
    drive(1, 16'h000B, 16'h0000, 1'b0);
    tick();
    chk("ovf_no_drop_b", m1_drop_o, 0);
    drive(1, 16'h000C, 16'h0000, 1'b0);
    tick();
    clr();
    chk("ovf_drop_c", m1_drop_o, 1);
    tick();
    chk("ovf_drop_pulse", m1_drop_o, 0);
    wait_resp(1, 20, n);
    chk("ovf_resp_a_cycle", n, 8);
    chk("ovf_resp_a_data", m1_data_o, 16'hBEF7);
    wait_bus(5, n);
    chk("ovf_issue_b_gap", n, 1);
    chk("ovf_issue_b_addr", bus_addr_o, 16'h000B);
    wait_resp(1, 20, n);
    chk("ovf_resp_b_cycle", n, 11);
    chk("ovf_resp_b_data", m1_data_o, 16'hBEF8);
    repeat (4) tick();
    chk("ovf_grants", gn - bg, 2);
    chk("ovf_drop_count", m1_dcnt - bd, 1);

    // Fairness with continuous re-requests
    do_reset();
    lat = 1;
    bg = gn;
    drive(0, 16'h0100, 16'h0000, 1'b0);
    drive(1, 16'h0200, 16'h0000, 1'b0);
    tick();
    for (int i = 0; i < 200 && gn < bg + 8; i++) begin
      m0_valid_i = m0_valid_o;
      m1_valid_i = m1_valid_o;
      tick();
    end
    clr();
    chk("fair_grant_count", (gn - bg >= 8) ? 1 : 0, 1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("fair_grant%0d", k), glog[bg + k], (k % 2 == 0) ? 16'h0100 : 16'h0200);
    end

    // Reset in the middle of WAIT
    do_reset();
    lat = 5;
    drive(0, 16'h0002, 16'h0000, 1'b0);
    tick();
    clr();
    tick();
    chk("rw_busy_before", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_busy", busy_o, 0);
    chk("rw_bus_valid", bus_valid_o, 0);
    chk("rw_bus_addr", bus_addr_o, 0);
    chk("rw_m_valid", {m0_valid_o, m1_valid_o}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    b0 = m0_vcnt; b1 = m1_vcnt; bg = gn;
    inj_data = 16'h1234; inj_rw = 1'b0; inj_vld = 1'b1;
    tick();
    inj_vld = 1'b0;
    repeat (8) tick();
    chk("rw_late_m0", m0_vcnt - b0, 0);
    chk("rw_late_m1", m1_vcnt - b1, 0);
    chk("rw_slots_empty", gn - bg, 0);
    chk("rw_idle", busy_o, 0);

`ifdef ARB_TIMEOUT_EN
    // Chain never responds: forced response after 16 WAIT cycles
    do_reset();
    lat = 0;
    drive(0, 16'h0005, 16'h0000, 1'b0);
    tick();
    clr();
    chk("to_issue", bus_valid_o, 1);
    drive(1, 16'h0007, 16'h0000, 1'b0);
    tick();
    clr();
    wait_resp(0, 40, n);
    chk("to_cycle", n, 15);
    chk("to_pulse", timeout_o, 1);
    chk("to_m0_data", m0_data_o, 16'h0000);
    chk("to_m0_rw", m0_rw_o, 0);
    wait_bus(5, n);
    chk("to_next_gap", n, 1);
    chk("to_next_addr", bus_addr_o, 16'h0007);
    tick();
    chk("to_pulse_end", timeout_o, 0);
`else
    // Without the timeout feature WAIT holds indefinitely
    do_reset();
    lat = 0;
    b0 = m0_vcnt; n = to_pulses;
    drive(0, 16'h0005, 16'h0000, 1'b0);
    tick();
    clr();
    repeat (40) tick();
    chk("nto_busy", busy_o, 1);
    chk("nto_no_resp", m0_vcnt - b0, 0);
    chk("nto_no_timeout", to_pulses - n, 0);
`endif

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
